// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one unified memory between the CPU and a DMA/debug port.
// Accesses run IDLE -> ISSUE -> RESP; a DMA burst lock can chain grants up to LOCK_MAX deep.
module mem_arbiter #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 16,
    parameter int LOCK_MAX = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_ack,
    output logic [DATA_W-1:0] dma_rdata,
    input  logic              dma_lock,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              owner
);
    localparam int CNT_W = ($clog2(LOCK_MAX + 1) > 4) ? $clog2(LOCK_MAX + 1) : 4;
    localparam logic [CNT_W-1:0] LOCK_LIMIT = CNT_W'(LOCK_MAX);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]  lock_cnt_q, lock_cnt_d;
    logic              grant;
    logic              grant_port;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        lock_cnt_d = lock_cnt_q;
        grant      = 1'b0;
        grant_port = owner_q;

        unique case (state_q)
            IDLE: begin
                if (cpu_req || dma_req) begin
                    grant      = 1'b1;
                    grant_port = (cpu_req && dma_req) ? ~owner_q : dma_req;
                end
            end
            ISSUE: state_d = RESP;
            RESP: begin
                // The finishing port still holds req this cycle, so it is re-granted only through the lock.
                if (owner_q && dma_lock && dma_req && ((lock_cnt_q < LOCK_LIMIT) || !cpu_req)) begin
                    grant      = 1'b1;
                    grant_port = 1'b1;
                end else if (!owner_q && dma_req) begin
                    grant      = 1'b1;
                    grant_port = 1'b1;
                end else if (owner_q && cpu_req) begin
                    grant      = 1'b1;
                    grant_port = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (grant) begin
            state_d = ISSUE;
            owner_d = grant_port;
            we_d    = grant_port ? dma_we    : cpu_we;
            addr_d  = grant_port ? dma_addr  : cpu_addr;
            wdata_d = grant_port ? dma_wdata : cpu_wdata;
        end

        if (grant && !grant_port) begin
            lock_cnt_d = '0;
        end else if (grant && dma_lock) begin
            if (lock_cnt_q < LOCK_LIMIT) begin
                lock_cnt_d = lock_cnt_q + 1'b1;
            end
        end else if (!dma_lock) begin
            lock_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            owner_q    <= 1'b1;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            lock_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end

    assign mem_en    = (state_q == ISSUE);
    assign mem_we    = mem_en && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign owner     = owner_q;

    // Port 0 is the CPU, port 1 the DMA; read data is held between reads.
    logic [1:0]             ack;
    logic [1:0][DATA_W-1:0] rdata;

    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        logic [DATA_W-1:0] rdata_q, rdata_d;

        assign ack[gi] = (state_q == RESP) && (owner_q == (gi == 1));

        always_comb begin
            rdata_d = rdata_q;
            if (ack[gi] && !we_q) begin
                rdata_d = mem_rdata;
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                rdata_q <= '0;
            end else begin
                rdata_q <= rdata_d;
            end
        end

        assign rdata[gi] = rdata_d;
    end

    assign cpu_ack   = ack[0];
    assign dma_ack   = ack[1];
    assign cpu_rdata = rdata[0];
    assign dma_rdata = rdata[1];
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter for the single unified instruction/data memory of the Von Neumann processor. It shares that memory between the CPU datapath (fetch, load and store) and a DMA/debug loader port. The loader port is used to preload programs and inspect memory. The block sits between `cpu` and the memory array, serialises accesses, and returns read data with a completion acknowledge.

## Interface
Parameters:
- `ADDR_W`, 8: memory address width.
- `DATA_W`, 16: memory data width.
- `LOCK_MAX`, 8: maximum consecutive locked DMA accesses before the CPU is forced a turn.

Ports:
- `clk` in 1: single clock, rising-edge.
- `reset` in 1: synchronous, active-high.
- `cpu_req` in 1: CPU access request; held until `cpu_ack`.
- `cpu_we` in 1: 1 = write, 0 = read.
- `cpu_addr` in `ADDR_W`: CPU address.
- `cpu_wdata` in `DATA_W`: CPU write data.
- `cpu_ack` out 1: one-cycle pulse, access complete.
- `cpu_rdata` out `DATA_W`: read data, valid while `cpu_ack`=1.
- `dma_req`, `dma_we`, `dma_addr`, `dma_wdata`, `dma_ack`, `dma_rdata`: same meanings and widths for the DMA/debug port.
- `dma_lock` in 1: DMA requests back-to-back ownership (burst).
- `mem_en` out 1: memory access strobe.
- `mem_we` out 1: memory write enable.
- `mem_addr` out `ADDR_W`: memory address.
- `mem_wdata` out `DATA_W`: memory write data.
- `mem_rdata` in `DATA_W`: memory read data, valid the cycle after `mem_en`=1 with `mem_we`=0.
- `owner` out 1: current or last grant (0 = CPU, 1 = DMA), for debug.

## Operation
- FSM states are IDLE, ISSUE and RESP.
- IDLE: if any `*_req` is high, latch the winner's `we`/`addr`/`wdata` and go to ISSUE. Otherwise stay.
- ISSUE: drive `mem_en`=1, plus `mem_we`, `mem_addr` and `mem_wdata` from the latched request, for exactly one cycle. Then go to RESP.
- RESP: pulse the winner's `*_ack`=1. For reads, `*_rdata`=`mem_rdata`. For writes, `*_rdata` holds its previous value. Then go to IDLE, or straight to ISSUE if the next winner is already requesting.
- Arbitration is round-robin on the `owner` pointer: when both requesters are high, grant the one not granted last. Reset sets `owner`=1, so the CPU wins the first tie.
- Lock: a DMA burst continues through consecutive accesses when all of the following hold:
  - `owner`=1, and `dma_lock`=1 and `dma_req`=1 at the RESP→next decision;
  - fewer than `LOCK_MAX` consecutive locked grants have been made.
  - The lock counter is 4 bits wide minimum and clears on any CPU grant or on `dma_lock`=0.
  - At `LOCK_MAX`, a pending `cpu_req` wins the next grant.
- Request inputs are sampled only at grant. Dropping `req` after grant does not abort: the access completes and `ack` still pulses.
- Only the granted port ever sees `ack`. The two acks are never high together.
- A port's `*_ack` never pulses without a preceding grant to that port.

## Timing
- Reset: on the first rising edge with `reset`=1, every output goes to 0 except `owner`=1. State goes to IDLE and the lock counter is cleared.
  - An access in flight is abandoned: no `ack`, no further `mem_en`.
  - A write already strobed in ISSUE has completed; one not yet in ISSUE is not performed.
- All outputs are registered or decoded from registered state. There are no combinational paths from `*_req` to `mem_*` or `*_ack`.
- Latency from IDLE: `req` high at edge N, then `mem_en` high in cycle N+1, then `ack` in cycle N+2.
- Throughput is one access per 2 cycles with back-to-back grants (RESP→ISSUE). A lone access occupies 3 cycles including IDLE.
- If `reset` and `req` are high on the same edge, reset wins and there is no grant.
- Address and data are passed through unmodified. No wrap or arithmetic.

## Test plan
- CPU read alone: mem[0x10]=0xBEEF, `cpu_req`=1, `cpu_we`=0, `cpu_addr`=0x10 → `mem_en` exactly once, `cpu_ack` 2 cycles after request, `cpu_rdata`=0xBEEF, `dma_ack` stays 0.
- DMA write then CPU read of the same address: DMA writes 0x1234 to 0x20, then the CPU reads 0x20 → `cpu_rdata`=0x1234.
- Simultaneous requests held continuously by both ports → grants alternate CPU, DMA, CPU, DMA… (CPU first after reset), and each ack is 2 cycles apart.
- `dma_lock`=1 with both ports requesting (`LOCK_MAX`=8) → exactly 8 consecutive DMA acks, then one CPU ack. With `cpu_req`=0 the DMA burst continues unbroken.
- `reset` pulsed in the ISSUE cycle of a CPU write → no `cpu_ack`, all outputs 0 and `owner`=1 after the edge, next CPU request is serviced normally.
- `cpu_req` dropped the cycle after grant → the access still completes and `cpu_ack` pulses once. No spurious second access.
